// File: rtl/fd_multi_if.sv
// Divisor write bus for fd_multi: write strobe, channel, value and the reject pulse.
interface fd_multi_if #(
   parameter int CH_W  = 2,
   parameter int DIV_W = 16
);
   logic             i_wr_en;
   logic [CH_W-1:0]  i_wr_ch;
   logic [DIV_W-1:0] i_wr_div;
   logic             o_wr_err;

   // Side that issues divisor writes and observes rejects
   modport master (
      output i_wr_en,
      output i_wr_ch,
      output i_wr_div,
      input  o_wr_err
   );

   // Divider side: accepts writes and reports rejects
   modport slave (
      input  i_wr_en,
      input  i_wr_ch,
      input  i_wr_div,
      output o_wr_err
   );
endinterface

// File: rtl/fd_multi.sv
// Multi-channel runtime-programmable clock divider. Each channel emits a near-50% clock level
// and a one-cycle tick per period; divisor changes are deferred to a period boundary so no
// runt pulse can appear on the output.
module fd_multi #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 500,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              i_clk_50MHz,
   input  logic              i_rst_n,
   input  logic [NUM_CH-1:0] i_en,
   input  logic              i_sync,
   fd_multi_if.slave         wr,
   output logic [NUM_CH-1:0] o_clk_out,
   output logic [NUM_CH-1:0] o_tick
);

   localparam int               CH_SPAN = 1 << CH_W;
   // One bit per encodable channel index, set only for channels that exist
   localparam logic [CH_SPAN-1:0] CH_MASK = {CH_SPAN{1'b1}} >> (CH_SPAN - NUM_CH);
   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

   logic [NUM_CH-1:0][DIV_W-1:0] cnt_r;
   logic [NUM_CH-1:0][DIV_W-1:0] act_r;
   logic [NUM_CH-1:0][DIV_W-1:0] pend_r;
   logic [NUM_CH-1:0]            run_r;
   logic [NUM_CH-1:0]            clk_r;
   logic [NUM_CH-1:0]            tick_r;
   logic                         wr_err_r;

   logic [NUM_CH-1:0][DIV_W-1:0] cnt_nx_s;
   logic [NUM_CH-1:0][DIV_W-1:0] act_nx_s;
   logic [NUM_CH-1:0][DIV_W-1:0] pend_nx_s;
   logic [NUM_CH-1:0][DIV_W-1:0] hi_s;
   logic [NUM_CH-1:0]            restart_s;
   logic [NUM_CH-1:0]            clk_nx_s;
   logic [NUM_CH-1:0]            tick_nx_s;
   logic                         wr_ok_s;
   logic                         wr_bad_s;

   // Classify the incoming write as accepted or rejected
   always_comb begin
      wr_ok_s  = 1'b0;
      wr_bad_s = 1'b0;
      if (wr.i_wr_en) begin
         if ((wr.i_wr_div >= MIN_DIV) && CH_MASK[wr.i_wr_ch]) begin
            wr_ok_s = 1'b1;
         end else begin
            wr_bad_s = 1'b1;
         end
      end else begin
         wr_ok_s  = 1'b0;
         wr_bad_s = 1'b0;
      end
   end

   // Per-channel next state: pending bypass, period restart, counter advance, output decode
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         pend_nx_s[c] = pend_r[c];
         cnt_nx_s[c]  = cnt_r[c];
         act_nx_s[c]  = act_r[c];
         // A write landing on the same edge as a boundary must take effect there
         if (wr_ok_s && (wr.i_wr_ch == CH_W'(c))) begin
            pend_nx_s[c] = wr.i_wr_div;
         end else begin
            pend_nx_s[c] = pend_r[c];
         end
         restart_s[c] = !run_r[c] || i_sync || (cnt_r[c] == (act_r[c] - ONE));
         if (!i_en[c]) begin
            cnt_nx_s[c] = '0;
            act_nx_s[c] = pend_nx_s[c];
         end else if (restart_s[c]) begin
            cnt_nx_s[c] = '0;
            act_nx_s[c] = pend_nx_s[c];
         end else begin
            cnt_nx_s[c] = cnt_r[c] + ONE;
            act_nx_s[c] = act_r[c];
         end
         // High phase is the ceiling half so odd divisors lean high
         hi_s[c]      = act_nx_s[c] - (act_nx_s[c] >> 1);
         clk_nx_s[c]  = i_en[c] && (cnt_nx_s[c] < hi_s[c]);
         tick_nx_s[c] = i_en[c] && (cnt_nx_s[c] == (act_nx_s[c] - ONE));
      end
   end

   // Channel state and registered outputs
   always_ff @(posedge i_clk_50MHz or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_r[c]  <= '0;
            act_r[c]  <= DEF_DIV;
            pend_r[c] <= DEF_DIV;
         end
         run_r    <= '0;
         clk_r    <= '0;
         tick_r   <= '0;
         wr_err_r <= 1'b0;
      end else begin
         cnt_r    <= cnt_nx_s;
         act_r    <= act_nx_s;
         pend_r   <= pend_nx_s;
         run_r    <= i_en;
         clk_r    <= clk_nx_s;
         tick_r   <= tick_nx_s;
         wr_err_r <= wr_bad_s;
      end
   end

   assign o_clk_out   = clk_r;
   assign o_tick      = tick_r;
   assign wr.o_wr_err = wr_err_r;

endmodule

// File: tb/tb_fd_multi.sv
// Self-checking bench for fd_multi: directed scenarios plus random traffic against a
// timestamp-based reference model (period start time + divisor per channel).
module tb_fd_multi;
   localparam int NUM_CH = 4;
   localparam int DIV_W  = 16;
   localparam int DEFDIV = 500;
   localparam int CH_W   = 2;

   logic              clk;
   logic              rst_n;
   logic [NUM_CH-1:0] en;
   logic              sync;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   fd_multi_if #(.CH_W(CH_W), .DIV_W(DIV_W)) bus ();

   fd_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFDIV)) dut (
      .i_clk_50MHz (clk),
      .i_rst_n     (rst_n),
      .i_en        (en),
      .i_sync      (sync),
      .wr          (bus.slave),
      .o_clk_out   (clk_out),
      .o_tick      (tick)
   );

   // 50 MHz board clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: each running channel remembers the edge its period began on
   int                m_t0  [NUM_CH];
   int                m_d   [NUM_CH];
   int                m_p   [NUM_CH];
   bit                m_run [NUM_CH];
   int                cyc;
   logic [NUM_CH-1:0] exp_clk;
   logic [NUM_CH-1:0] exp_tick;
   logic              exp_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_t0[c] = 0; m_d[c] = DEFDIV; m_p[c] = DEFDIV; m_run[c] = 1'b0;
      end
      exp_clk = '0; exp_tick = '0; exp_err = 1'b0;
   endtask

   task automatic model_step();
      bit valid;
      int e;
      int pe;
      cyc++;
      valid   = (int'(bus.i_wr_div) >= 2) && (int'(bus.i_wr_ch) < NUM_CH);
      exp_err = bus.i_wr_en && !valid;
      for (int c = 0; c < NUM_CH; c++) begin
         pe = m_p[c];
         if (bus.i_wr_en && valid && int'(bus.i_wr_ch) == c) pe = int'(bus.i_wr_div);
         m_p[c] = pe;
         if (!en[c]) begin
            m_run[c] = 1'b0; m_d[c] = pe;
            exp_clk[c] = 1'b0; exp_tick[c] = 1'b0;
         end else begin
            if (!m_run[c] || sync || (cyc - m_t0[c]) >= m_d[c]) begin
               m_t0[c] = cyc; m_d[c] = pe;
            end
            m_run[c]    = 1'b1;
            e           = cyc - m_t0[c];
            exp_clk[c]  = (e < (m_d[c] + 1) / 2);
            exp_tick[c] = (e == m_d[c] - 1);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      #1;
      check_eq("clk_out", 32'(clk_out), 32'(exp_clk));
      check_eq("tick", 32'(tick), 32'(exp_tick));
      check_eq("wr_err", 32'(bus.o_wr_err), 32'(exp_err));
   endtask

   task automatic write_div(input int ch, input int dv);
      bus.i_wr_en  = 1'b1;
      bus.i_wr_ch  = CH_W'(ch);
      bus.i_wr_div = DIV_W'(dv);
      step();
      bus.i_wr_en  = 1'b0;
   endtask

   int hi_cnt;
   int tk_cnt;
   int tk0;
   int tk1;

   initial begin
      rst_n = 1'b0; en = '0; sync = 1'b0;
      bus.i_wr_en = 1'b0; bus.i_wr_ch = '0; bus.i_wr_div = '0;
      cyc = 0;
      model_reset();

      // 1: reset state, then ch0 at the default divisor
      repeat (3) step();
      #2 rst_n = 1'b1;
      repeat (2) step();
      check_eq("reset_outs", 32'({clk_out, tick, bus.o_wr_err}), 32'd0);
      en[0] = 1'b1;
      hi_cnt = 0; tk_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         hi_cnt += int'(clk_out[0]);
         tk_cnt += int'(tick[0]);
      end
      check_eq("t1_high_500", 32'(hi_cnt), 32'd500);
      check_eq("t1_ticks", 32'(tk_cnt), 32'd2);

      // 2: ch1 at divisor 5 -> 3 high / 2 low
      write_div(1, 5);
      en[1] = 1'b1;
      hi_cnt = 0; tk_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         hi_cnt += int'(clk_out[1]);
         tk_cnt += int'(tick[1]);
      end
      check_eq("t2_high", 32'(hi_cnt), 32'd12);
      check_eq("t2_ticks", 32'(tk_cnt), 32'd4);

      // 3: ch2 at 4, change to 6 while cnt==1
      write_div(2, 4);
      en[2] = 1'b1;
      step();              // cnt=0
      write_div(2, 6);     // edge giving cnt=1 ... write seen at next edge
      hi_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         hi_cnt += int'(clk_out[2]);
      end
      repeat (24) step();

      // 4: rejected writes leave ch0 untouched
      write_div(0, 1);
      check_eq("t4_err_div1", 32'(bus.o_wr_err), 32'd1);
      write_div(0, 0);
      check_eq("t4_err_div0", 32'(bus.o_wr_err), 32'd1);
      step();
      check_eq("t4_err_clear", 32'(bus.o_wr_err), 32'd0);
      repeat (50) step();

      // 5: ch0=4, ch1=8, then sync aligns them
      write_div(0, 4);
      write_div(1, 8);
      repeat (520) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      check_eq("t5_sync_rise", 32'(clk_out[1:0]), 32'd3);
      tk0 = 0; tk1 = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         tk0 += int'(tick[0]);
         tk1 += int'(tick[1]);
      end
      check_eq("t5_ticks_ch0", 32'(tk0), 32'd4);
      check_eq("t5_ticks_ch1", 32'(tk1), 32'd2);

      // 6a: drop enable mid-period
      repeat (2) step();
      en[1] = 1'b0;
      step();
      check_eq("t6_dis_clk", 32'(clk_out[1]), 32'd0);
      check_eq("t6_dis_tick", 32'(tick[1]), 32'd0);
      repeat (10) step();
      en[1] = 1'b1;

      // 6b: asynchronous reset between edges
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1 check_eq("t6_async_rst", 32'({clk_out, tick, bus.o_wr_err}), 32'd0);
      repeat (2) step();
      #2 rst_n = 1'b1;
      repeat (30) step();

      // Random traffic: writes (some invalid), syncs and enable toggles
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            bus.i_wr_en  = 1'b1;
            bus.i_wr_ch  = CH_W'($urandom_range(0, NUM_CH - 1));
            bus.i_wr_div = DIV_W'($urandom_range(0, 12));
         end else begin
            bus.i_wr_en = 1'b0;
         end
         sync = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 59) == 0) begin
            int idx;
            idx = int'($urandom_range(0, NUM_CH - 1));
            en[idx] = ~en[idx];
         end
         step();
      end
      bus.i_wr_en = 1'b0;
      sync = 1'b0;
      repeat (5) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
